// File: rtl/full_calc_ctrl.sv
// Sequencing FSM for the full calculator datapath: operand capture, unit launch, completion wait, L/H write-back.
// Optional wait-state timeout is compiled in with `define FULL_CALC_CTRL_TIMEOUT_EN.
module full_calc_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Go,
   input  logic [2:0] F,
   input  logic       sm_calc_Done,
   input  logic       div_Done,
   output logic       X_en,
   output logic       Y_en,
   output logic [1:0] Y_Sel,
   output logic       sm_calc_Go,
   output logic [1:0] sm_calc_Op,
   output logic       div_Go,
   output logic       OutL_en,
   output logic       OutH_en,
   output logic [1:0] Sel_L,
   output logic [1:0] Sel_H,
   output logic       div_Err_en,
   output logic       Done,
   output logic       Err,
   output logic [3:0] CS
);

   if (MUL_LAT < 1 || MUL_LAT > 256 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
      $error("full_calc_ctrl: MUL_LAT must be 1..256 and TIMEOUT 1..255");
   end

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CALC_GO   = 3'd1,
      S_CALC_WAIT = 3'd2,
      S_MUL_WAIT  = 3'd3,
      S_DIV_GO    = 3'd4,
      S_DIV_WAIT  = 3'd5,
      S_WB        = 3'd6,
      S_DONE      = 3'd7
   } state_t;

   localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       f_rsv;

   // Codes 110/111 are reserved and never touch the operand registers.
   assign f_rsv = (F[2:1] == 2'b11);

`ifdef FULL_CALC_CTRL_TIMEOUT_EN
   localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);
   logic tmo_hit;
   assign tmo_hit = (({1'b0, cnt_q} + 9'd1) == TMO_LIM);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 3'b000;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (Go) begin
               if (f_rsv) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  op_d = F;
                  if (!F[2]) begin
                     state_d = S_CALC_GO;
                  end else if (!F[0]) begin
                     state_d = S_MUL_WAIT;
                     cnt_d   = MUL_LOAD;
                  end else begin
                     state_d = S_DIV_GO;
                  end
               end
            end
         end
         S_CALC_GO: begin
            state_d = S_CALC_WAIT;
`ifdef FULL_CALC_CTRL_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         // A Done seen on the limit cycle still wins over the timeout.
         S_CALC_WAIT: begin
            if (sm_calc_Done) begin
               state_d = S_WB;
            end
`ifdef FULL_CALC_CTRL_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_MUL_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DIV_GO: begin
            state_d = S_DIV_WAIT;
`ifdef FULL_CALC_CTRL_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         S_DIV_WAIT: begin
            if (div_Done) begin
               state_d = S_WB;
            end
`ifdef FULL_CALC_CTRL_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_WB: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore decode; the IDLE operand load is the only Go-dependent output.
   always_comb begin
      X_en       = 1'b0;
      Y_en       = 1'b0;
      Y_Sel      = 2'b00;
      sm_calc_Go = 1'b0;
      sm_calc_Op = 2'b00;
      div_Go     = 1'b0;
      OutL_en    = 1'b0;
      OutH_en    = 1'b0;
      Sel_L      = 2'b00;
      Sel_H      = 2'b00;
      div_Err_en = 1'b0;
      Done       = 1'b0;
      Err        = 1'b0;
      CS         = {1'b0, state_q};
      case (state_q)
         S_IDLE: begin
            if (Go && !f_rsv) begin
               X_en  = 1'b1;
               Y_en  = 1'b1;
               Y_Sel = 2'b01;
            end
         end
         S_CALC_GO: begin
            sm_calc_Go = 1'b1;
            sm_calc_Op = op_q[1:0];
         end
         S_CALC_WAIT: begin
            sm_calc_Op = op_q[1:0];
         end
         S_DIV_GO: begin
            div_Go = 1'b1;
         end
         S_WB: begin
            OutL_en = 1'b1;
            OutH_en = 1'b1;
            if (!op_q[2]) begin
               Sel_L = 2'b00;
               Sel_H = 2'b10;
            end else if (!op_q[0]) begin
               Sel_L = 2'b01;
               Sel_H = 2'b00;
            end else begin
               Sel_L      = 2'b10;
               Sel_H      = 2'b01;
               div_Err_en = 1'b1;
            end
         end
         S_DONE: begin
            Done = 1'b1;
            Err  = err_q;
         end
         default: begin
            CS = {1'b0, state_q};
         end
      endcase
   end

endmodule

// File: tb/tb_full_calc_ctrl.sv
// Randomized bench for full_calc_ctrl with a behavioural datapath and a timeline-based reference.
module tb_full_calc_ctrl;
   localparam int MUL_LAT = 3;
   localparam int TIMEOUT = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       Go;
   logic [2:0] F;
   logic       sm_calc_Done, div_Done;
   logic       X_en, Y_en, sm_calc_Go, div_Go, OutL_en, OutH_en, div_Err_en, Done, Err;
   logic [1:0] Y_Sel, sm_calc_Op, Sel_L, Sel_H;
   logic [3:0] CS;

   full_calc_ctrl #(.MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .Go(Go), .F(F),
      .sm_calc_Done(sm_calc_Done), .div_Done(div_Done),
      .X_en(X_en), .Y_en(Y_en), .Y_Sel(Y_Sel),
      .sm_calc_Go(sm_calc_Go), .sm_calc_Op(sm_calc_Op), .div_Go(div_Go),
      .OutL_en(OutL_en), .OutH_en(OutH_en), .Sel_L(Sel_L), .Sel_H(Sel_H),
      .div_Err_en(div_Err_en), .Done(Done), .Err(Err), .CS(CS)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [20:0] obs;
   assign obs = {X_en, Y_en, Y_Sel, sm_calc_Go, sm_calc_Op, div_Go, OutL_en, OutH_en,
                 Sel_L, Sel_H, div_Err_en, Done, Err, CS};

   // Behavioural datapath driven by the controller's enables and selects
   logic [3:0] A = 4'd0, B = 4'd0;
   logic [3:0] xr = 4'd0, yr = 4'd0, lr = 4'd0, hr = 4'd0, sm_res = 4'd0, q_r = 4'd0, r_r = 4'd0;
   logic       dz = 1'b0;
   logic [7:0] prod;
   assign prod = {4'b0, xr} * {4'b0, yr};

   always @(posedge clk) begin
      if (X_en) xr <= A;
      if (Y_en) begin
         case (Y_Sel)
            2'b00:   yr <= A;
            2'b01:   yr <= B;
            2'b10:   yr <= 4'd1;
            default: yr <= 4'd0;
         endcase
      end
      if (sm_calc_Go) begin
         case (sm_calc_Op)
            2'b00:   sm_res <= xr + yr;
            2'b01:   sm_res <= xr - yr;
            2'b10:   sm_res <= xr & yr;
            default: sm_res <= xr ^ yr;
         endcase
      end
      if (div_Go) begin
         if (yr == 4'd0) begin
            q_r <= 4'hF;
            r_r <= xr;
         end else begin
            q_r <= xr / yr;
            r_r <= xr % yr;
         end
      end
      if (OutL_en) begin
         case (Sel_L)
            2'b00:   lr <= sm_res;
            2'b01:   lr <= prod[3:0];
            2'b10:   lr <= q_r;
            default: lr <= 4'd0;
         endcase
      end
      if (OutH_en) begin
         case (Sel_H)
            2'b00:   hr <= prod[7:4];
            2'b01:   hr <= r_r;
            default: hr <= 4'd0;
         endcase
      end
      if (div_Err_en) dz <= (yr == 4'd0);
   end

   logic [3:0] exp_l = 4'd0, exp_h = 4'd0;

   // Expected controller outputs in cycle c of a transaction whose DONE cycle is 'last'
   function automatic logic [20:0] exp_vec(input logic [2:0] f, input int c, input int last, input bit tmo);
      logic xe, ye, scg, dg, le, he, de, dn, er;
      logic [1:0] ys, sop, sl, sh;
      logic [3:0] cs;
      bit rsv, calc, mul;
      xe = 0; ye = 0; scg = 0; dg = 0; le = 0; he = 0; de = 0; dn = 0; er = 0;
      ys = 0; sop = 0; sl = 0; sh = 0; cs = 0;
      rsv  = (f[2:1] == 2'b11);
      calc = !f[2];
      mul  = (f == 3'b100);
      if (c == 0) begin
         if (!rsv) begin xe = 1; ye = 1; ys = 2'b01; end
      end else if (c == last) begin
         cs = 4'd7; dn = 1; er = rsv || tmo;
      end else if (c == last - 1 && !tmo) begin
         cs = 4'd6; le = 1; he = 1;
         if (calc)     begin sl = 2'b00; sh = 2'b10; end
         else if (mul) begin sl = 2'b01; sh = 2'b00; end
         else          begin sl = 2'b10; sh = 2'b01; de = 1; end
      end else if (mul) begin
         cs = 4'd3;
      end else if (c == 1) begin
         if (calc) begin cs = 4'd1; scg = 1; sop = f[1:0]; end
         else      begin cs = 4'd4; dg = 1; end
      end else begin
         if (calc) begin cs = 4'd2; sop = f[1:0]; end
         else      cs = 4'd5;
      end
      return {xe, ye, ys, scg, sop, dg, le, he, sl, sh, de, dn, er, cs};
   endfunction

   // One operation from its IDLE/Go cycle through DONE; ds = completion cycle (pulse) or first high cycle (level)
   task automatic run_txn(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                          input int ds, input bit pulse, input bit hold, input bit nodone);
      int k, last;
      bit rsv, calc;
      logic rel;
      logic [7:0] p;
      logic [3:0] el, eh;
      rsv  = (f[2:1] == 2'b11);
      calc = !f[2];
      k    = pulse ? ds : ((ds < 2) ? 2 : ds);
      if (rsv)                last = 1;
      else if (f == 3'b100)   last = MUL_LAT + 2;
      else if (nodone)        last = TIMEOUT + 2;
      else                    last = k + 2;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         Go = (c == 0) || hold;
         F  = (c == 0) ? f : 3'($urandom);
         A  = a;
         B  = b;
         rel = nodone ? 1'b0 : (pulse ? (c == ds) : (c >= ds));
         sm_calc_Done = 1'($urandom);
         div_Done     = 1'($urandom);
         if (!rsv && f != 3'b100) begin
            if (calc) sm_calc_Done = rel;
            else      div_Done     = rel;
         end
         #1;
         chk($sformatf("ctl f=%0d c=%0d", f, c), 32'(obs), 32'(exp_vec(f, c, last, nodone)));
         if (c == last) begin
            if (!rsv && !nodone) begin
               p = {4'b0, a} * {4'b0, b};
               case (f)
                  3'b000:  begin el = a + b; eh = 4'd0; end
                  3'b001:  begin el = a - b; eh = 4'd0; end
                  3'b010:  begin el = a & b; eh = 4'd0; end
                  3'b011:  begin el = a ^ b; eh = 4'd0; end
                  3'b100:  begin el = p[3:0]; eh = p[7:4]; end
                  default: begin
                     if (b == 4'd0) begin el = 4'hF; eh = a; end
                     else begin el = a / b; eh = a % b; end
                  end
               endcase
               exp_l = el;
               exp_h = eh;
               if (f == 3'b101) chk($sformatf("divby0 a=%0d b=%0d", a, b), 32'(dz), 32'(b == 4'd0));
            end
            chk($sformatf("L f=%0d a=%0d b=%0d", f, a, b), 32'(lr), 32'(exp_l));
            chk($sformatf("H f=%0d a=%0d b=%0d", f, a, b), 32'(hr), 32'(exp_h));
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         Go = 1'b0;
         F  = 3'($urandom);
         sm_calc_Done = 1'($urandom);
         div_Done     = 1'($urandom);
         #1;
         chk("idle", 32'(obs), 32'd0);
      end
   endtask

   initial begin
      int n5;
      bit pl;
      rst = 1'b1; Go = 1'b0; F = 3'd0; sm_calc_Done = 1'b0; div_Done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 chk("reset outputs", 32'(obs), 32'd0);
      rst = 1'b0;
      idle_cycles(2);

      run_txn(3'b100, 4'd6, 4'd7, 1, 1'b0, 1'b0, 1'b0);
      run_txn(3'b101, 4'd9, 4'd4, 5, 1'b1, 1'b0, 1'b0);
      run_txn(3'b001, 4'd5, 4'd3, 1, 1'b0, 1'b0, 1'b0);
      run_txn(3'b111, 4'd1, 4'd2, 1, 1'b0, 1'b1, 1'b0);
      run_txn(3'b000, 4'd7, 4'd12, 3, 1'b1, 1'b0, 1'b0);
      run_txn(3'b101, 4'd11, 4'd0, 2, 1'b0, 1'b0, 1'b0);
      idle_cycles(1);

      // Reset while waiting on the divider
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         Go = (c == 0); F = 3'b101; A = 4'd9; B = 4'd4; div_Done = 1'b0;
         #1 chk($sformatf("pre-rst c=%0d", c), 32'(obs), 32'(exp_vec(3'b101, c, 100, 1'b0)));
      end
      @(negedge clk);
      rst = 1'b1;
      #1 chk("async rst", 32'(obs), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("after rst", 32'(obs), 32'd0);
      run_txn(3'b011, 4'd10, 4'd6, 4, 1'b1, 1'b0, 1'b0);

      for (int t = 0; t < 120; t++) begin
         logic [2:0] f;
         bit hold;
         f    = 3'($urandom);
         pl   = 1'($urandom);
         hold = ($urandom % 4) == 0;
         run_txn(f, 4'($urandom), 4'($urandom),
                 pl ? int'($urandom_range(2, 8)) : int'($urandom_range(1, 8)), pl, hold, 1'b0);
         if (!hold) idle_cycles(int'($urandom % 3));
      end
      idle_cycles(1);

`ifdef FULL_CALC_CTRL_TIMEOUT_EN
      run_txn(3'b101, 4'd3, 4'd1, 1, 1'b0, 1'b0, 1'b1);
      run_txn(3'b010, 4'd3, 4'd1, 1, 1'b0, 1'b0, 1'b1);
      idle_cycles(1);
`else
      n5 = 0;
      for (int c = 0; c < 1002; c++) begin
         @(negedge clk);
         Go = (c == 0); F = (c == 0) ? 3'b101 : 3'($urandom);
         A = 4'd3; B = 4'd1; div_Done = 1'b0; sm_calc_Done = 1'($urandom);
         #1;
         if (c >= 2 && CS == 4'd5) n5++;
      end
      chk("div wait hold cycles", 32'(n5), 32'd1000);
      chk("no writeback while waiting", 32'(OutL_en), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst from wait", 32'(obs), 32'd0);
`endif
      run_txn(3'b100, 4'd15, 4'd15, 1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
